edge_pulse_debounce: RTL and testbench

Multi-channel, parametrised successor to the single-bit one-shot. Each channel does three things:
- Synchronises an asynchronous level input.
- Debounces it with a per-channel stability counter.
- Emits a one-cycle pulse on the selected edge type (rise, fall, both, off).

It sits between board-level inputs (buttons, switches, external strobes) and the control FSMs that consume single-cycle events.

---
 rtl/mdr_pkg.sv | 32 +++
 rtl/debounce_ch.sv | 94 +++++++++
 rtl/edge_pulse_debounce.sv | 44 ++++
 tb/tb_edge_pulse_debounce.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types and defaults for the multi-channel edge/pulse debouncer.
package mdr_pkg;

  // Edge selection, shared by every channel of a debouncer instance.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  // Default geometry of the block.
  localparam int NCH_DEF      = 4;
  localparam int SYNC_DEF     = 2;
  localparam int DEBOUNCE_DEF = 4;

  // Decide whether an accepted level change is an event of interest.
  // new_level is the level that has just been accepted.
  function automatic logic edge_hit(input edge_mode_t m, input logic new_level);
    logic hit;
    hit = 1'b0;
    case (m)
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      EDGE_BOTH: hit = 1'b1;
      EDGE_OFF:  hit = 1'b0;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage : mdr_pkg

// File: rtl/debounce_ch.sv
// One debouncer channel: synchroniser, stability counter, accepted level
// and a registered one-cycle event pulse.
//
// Control priority at each rising clock edge:
//   sync_rst=1        -> everything cleared, even with enb=0
//   enb=0             -> all state held, pulse registered to 0
//   enb=1             -> synchroniser shifts, counter/level/pulse advance
// There is no handshake: data_in is a free-running level and pulse_out is
// a single-cycle strobe with no backpressure.
module debounce_ch
  import mdr_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       sync_rst,
  input  logic       data_in,
  input  logic [1:0] mode,
  output logic       level_out,
  output logic       pulse_out
);

  // Counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;

  logic                   synced;
  logic                   update;
  edge_mode_t             mode_e;

  assign synced = sync_q[SYNC_STAGES-1];
  assign mode_e = edge_mode_t'(mode);

  // Next-state logic: synchroniser shift, debounce count and event decision.
  always_comb begin
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    update  = 1'b0;

    if (sync_rst) begin
      sync_d  = '0;
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (enb) begin
      // sync[0] takes the raw input, each later stage takes its predecessor.
      sync_d = {sync_q[SYNC_STAGES-2:0], data_in};

      if (synced == level_q) begin
        // Input agrees with the accepted level: any partial count is void.
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        // New level has held long enough; accept it on this edge.
        level_d = synced;
        cnt_d   = '0;
        update  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end

      // Mode matters only at the edge where the level is accepted.
      pulse_d = update & edge_hit(mode_e, synced);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;

endmodule : debounce_ch

// File: rtl/edge_pulse_debounce.sv
// Multi-channel synchronise/debounce/edge-pulse block. Each channel is an
// independent debounce_ch; this level only fans out the shared controls
// and mode, and ORs the per-channel pulses into any_pulse.
module edge_pulse_debounce
  import mdr_pkg::*;
#(
  parameter int NCH             = NCH_DEF,
  parameter int SYNC_STAGES     = SYNC_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enb,
  input  logic           sync_rst,
  input  logic [NCH-1:0] data_in,
  input  logic [1:0]     mode,
  output logic [NCH-1:0] level_out,
  output logic [NCH-1:0] pulse_out,
  output logic           any_pulse
);

  // One debouncer per input bit; channels share only clock, controls and mode.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .sync_rst (sync_rst),
      .data_in  (data_in[c]),
      .mode     (mode),
      .level_out(level_out[c]),
      .pulse_out(pulse_out[c])
    );
  end

  // Registered pulses are ORed combinationally, so any_pulse is also one cycle.
  always_comb begin
    any_pulse = |pulse_out;
  end

endmodule : edge_pulse_debounce

// File: tb/tb_edge_pulse_debounce.sv
// Bench for edge_pulse_debounce: directed scenarios followed by a random
// phase, all compared against a run-length reference model.
module tb_edge_pulse_debounce;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, enb, sync_rst;
  logic [NCH-1:0] data_in;
  logic [1:0]     mode;
  logic [NCH-1:0] level_out, pulse_out;
  logic           any_pulse;

  // Corner instance: 8 channels, 3 sync stages, 1-cycle debounce.
  logic [7:0] data2;
  logic [1:0] mode2;
  logic [7:0] level2, pulse2;
  logic       any2;

  edge_pulse_debounce #(.NCH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .enb(enb), .sync_rst(sync_rst), .data_in(data_in),
    .mode(mode), .level_out(level_out), .pulse_out(pulse_out), .any_pulse(any_pulse)
  );

  edge_pulse_debounce #(.NCH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .enb(enb), .sync_rst(sync_rst), .data_in(data2),
    .mode(mode2), .level_out(level2), .pulse_out(pulse2), .any_pulse(any2)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  int pcnt [NCH];

  logic           m_hist [NCH][$];  // raw samples still inside the synchroniser
  int             m_run  [NCH];     // consecutive enabled edges seen disagreeing
  logic [NCH-1:0] m_level;
  logic [NCH-1:0] m_pulse;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_hist[c].delete();
      repeat (SYNC) m_hist[c].push_back(1'b0);
      m_run[c] = 0;
    end
    m_level = '0;
    m_pulse = '0;
  endtask

  // A level is accepted once the synchronised input has disagreed with the
  // current level for DEB enabled edges in a row.
  task automatic model_edge();
    logic s;
    if (!rst || sync_rst) begin
      model_clear();
    end else if (!enb) begin
      m_pulse = '0;
    end else begin
      m_pulse = '0;
      for (int c = 0; c < NCH; c++) begin
        s = m_hist[c].pop_front();
        m_hist[c].push_back(data_in[c]);
        if (s == m_level[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DEB) begin
            m_level[c] = s;
            m_run[c]   = 0;
            case (mode)
              2'b00:   m_pulse[c] = s;
              2'b01:   m_pulse[c] = ~s;
              2'b10:   m_pulse[c] = 1'b1;
              default: m_pulse[c] = 1'b0;
            endcase
          end
        end
      end
    end
  endtask

  task automatic check_main();
    chk("level_out", 8'(level_out), 8'(m_level));
    chk("pulse_out", 8'(pulse_out), 8'(m_pulse));
    chk("any_pulse", 8'(any_pulse), 8'(|m_pulse));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_main();
    for (int c = 0; c < NCH; c++) if (pulse_out[c]) pcnt[c]++;
  endtask

  task automatic clear_pcnt();
    for (int c = 0; c < NCH; c++) pcnt[c] = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0; enb = 1'b1; sync_rst = 1'b0; data_in = '0; mode = 2'b00;
    data2 = '0; mode2 = 2'b10;
    model_clear();
    clear_pcnt();
    repeat (3) tick();
    chk("reset_level", 8'(level_out), 8'h00);

    // 1: single rising channel, pulse exactly at edge 6
    rst = 1'b1; data_in = 4'b0001;
    repeat (5) tick();
    chk("s1_pulse_e5", 8'(pulse_out), 8'h00);
    tick();
    chk("s1_pulse_e6", 8'(pulse_out), 8'h01);
    chk("s1_level_e6", 8'(level_out), 8'h01);
    chk("s1_any_e6",   8'(any_pulse), 8'h01);
    tick();
    chk("s1_pulse_e7", 8'(pulse_out), 8'h00);
    chk("s1_any_e7",   8'(any_pulse), 8'h00);

    // 2: bounce on channel 1, then a clean rise
    clear_pcnt();
    data_in[1] = 1'b1; repeat (3) tick();
    data_in[1] = 1'b0; tick();
    data_in[1] = 1'b1;
    repeat (5) tick();
    chk("s2_no_bounce_pulse", 8'(pcnt[1]), 8'd0);
    tick();
    chk("s2_pulse_e6", 8'(pulse_out[1]), 8'h01);
    repeat (4) tick();
    chk("s2_pulse_count", 8'(pcnt[1]), 8'd1);
    chk("s2_level",       8'(level_out[1]), 8'h01);

    // 3: mode sweep on channel 2
    mode = 2'b01; clear_pcnt();
    data_in[2] = 1'b1; repeat (10) tick();
    data_in[2] = 1'b0; repeat (10) tick();
    chk("s3_fall_count", 8'(pcnt[2]), 8'd1);
    mode = 2'b10; clear_pcnt();
    data_in[2] = 1'b1; repeat (10) tick();
    data_in[2] = 1'b0; repeat (10) tick();
    chk("s3_both_count", 8'(pcnt[2]), 8'd2);
    mode = 2'b11; clear_pcnt();
    data_in[2] = 1'b1; repeat (10) tick();
    chk("s3_off_level_hi", 8'(level_out[2]), 8'h01);
    data_in[2] = 1'b0; repeat (10) tick();
    chk("s3_off_level_lo", 8'(level_out[2]), 8'h00);
    chk("s3_off_count",    8'(pcnt[2]), 8'd0);

    // 4: enable dropped for 5 cycles mid-count
    mode = 2'b00; sync_rst = 1'b1; data_in = '0;
    tick();
    chk("s4_sync_clear", 8'(level_out), 8'h00);
    sync_rst = 1'b0; data_in = 4'b0001;
    repeat (4) tick();
    enb = 1'b0;
    repeat (5) tick();
    chk("s4_frozen_level", 8'(level_out), 8'h00);
    enb = 1'b1;
    tick();
    chk("s4_pulse_e10", 8'(pulse_out), 8'h00);
    tick();
    chk("s4_pulse_e11", 8'(pulse_out), 8'h01);

    // 5: async reset mid-count, then sync_rst with enable low
    tick();
    data_in = 4'b1001;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    model_clear();
    chk("s5_async_level", 8'(level_out), 8'h00);
    chk("s5_async_pulse", 8'(pulse_out), 8'h00);
    chk("s5_async_any",   8'(any_pulse), 8'h00);
    #2;
    rst = 1'b1;
    repeat (5) tick();
    chk("s5_pulse_e5", 8'(pulse_out), 8'h00);
    tick();
    chk("s5_pulse_e6", 8'(pulse_out), 8'h09);
    chk("s5_level_e6", 8'(level_out), 8'h09);
    tick();
    enb = 1'b0; sync_rst = 1'b1;
    tick();
    chk("s5_syncrst_noenb", 8'(level_out), 8'h00);
    enb = 1'b1; sync_rst = 1'b0;

    // 6: corner instance, both edges, 1-cycle debounce, 3 sync stages
    data2 = 8'hFF;
    repeat (3) tick();
    chk("s6_rise_e3", pulse2, 8'h00);
    tick();
    chk("s6_rise_e4",  pulse2, 8'hFF);
    chk("s6_level_hi", level2, 8'hFF);
    chk("s6_any",      8'(any2), 8'h01);
    tick();
    chk("s6_rise_e5", pulse2, 8'h00);
    data2 = 8'h00;
    repeat (3) tick();
    chk("s6_fall_e3", pulse2, 8'h00);
    tick();
    chk("s6_fall_e4",  pulse2, 8'hFF);
    chk("s6_level_lo", level2, 8'h00);

    // Random phase: slow toggles, sporadic enable drops, clears and resets
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) data_in[c] = ~data_in[c];
      enb      = ($urandom_range(0, 9) != 0);
      sync_rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        #1;
        model_clear();
        check_main();
        rst = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_edge_pulse_debounce
